// File: rtl/des3_seq_pkg.sv
// Shared types and default register map for the DES3 wishbone sequencer.
package des3_seq_pkg;

    typedef enum logic [3:0] {
        StIdle,
        StKeyWr,
        StDataWr,
        StModeWr,
        StStartSet,
        StStartClr,
        StPoll,
        StRd,
        StOut
    } seq_state_e;

    localparam int unsigned KEY_WORDS = 6;
    localparam int unsigned BLK_WORDS = 2;

    localparam int unsigned DEF_KEY_BASE   = 'h00;
    localparam int unsigned DEF_PT_BASE    = 'h18;
    localparam int unsigned DEF_MODE_ADDR  = 'h20;
    localparam int unsigned DEF_START_ADDR = 'h24;
    localparam int unsigned DEF_DONE_ADDR  = 'h28;
    localparam int unsigned DEF_CT_BASE    = 'h2C;
    localparam int unsigned DEF_POLL_MAX   = 64;

endpackage

// File: rtl/des3_wb_access.sv
// One wishbone classic single access per req; done pulses combinationally on the ack cycle so
// the sequencer can present the next request while the bus is in its mandatory idle cycle.
module des3_wb_access #(
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] adr,
    input  logic [31:0]           wdat,
    output logic                  done,
    output logic [31:0]           rdat,
    output logic [ADDR_WIDTH-1:0] wbm_adr_o,
    output logic [31:0]           wbm_dat_o,
    output logic [3:0]            wbm_sel_o,
    output logic                  wbm_we_o,
    output logic                  wbm_cyc_o,
    output logic                  wbm_stb_o,
    input  logic [31:0]           wbm_dat_i,
    input  logic                  wbm_ack_i
);

    logic                  cyc_q;
    logic                  we_q;
    logic [ADDR_WIDTH-1:0] adr_q;
    logic [31:0]           dat_q;

    // A request is only taken while the bus is idle, which enforces the gap after each ack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc_q <= 1'b0;
            we_q  <= 1'b0;
            adr_q <= '0;
            dat_q <= '0;
        end else if (cyc_q) begin
            if (wbm_ack_i) begin
                cyc_q <= 1'b0;
            end
        end else if (req) begin
            cyc_q <= 1'b1;
            we_q  <= we;
            adr_q <= adr;
            dat_q <= wdat;
        end
    end

    assign done      = cyc_q & wbm_ack_i;
    assign rdat      = wbm_dat_i;
    assign wbm_adr_o = adr_q;
    assign wbm_dat_o = dat_q;
    assign wbm_we_o  = we_q;
    assign wbm_cyc_o = cyc_q;
    assign wbm_stb_o = cyc_q;
    assign wbm_sel_o = {4{cyc_q}};

endmodule

// File: rtl/des3_wb_sequencer.sv
// Streams 64-bit blocks through a DES3 wishbone slave: lazy key reload, data/mode writes,
// start pulse, bounded done polling and result readback.
module des3_wb_sequencer
    import des3_seq_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned KEY_BASE   = DEF_KEY_BASE,
    parameter int unsigned PT_BASE    = DEF_PT_BASE,
    parameter int unsigned MODE_ADDR  = DEF_MODE_ADDR,
    parameter int unsigned START_ADDR = DEF_START_ADDR,
    parameter int unsigned DONE_ADDR  = DEF_DONE_ADDR,
    parameter int unsigned CT_BASE    = DEF_CT_BASE,
    parameter int unsigned POLL_MAX   = DEF_POLL_MAX
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    input  logic [191:0]          key_i,
    input  logic                  key_load_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [63:0]           in_data_i,
    input  logic                  in_decrypt_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [63:0]           out_data_o,
    output logic                  err_o,
    output logic                  busy_o,
    output logic [ADDR_WIDTH-1:0] wbm_adr_o,
    output logic [31:0]           wbm_dat_o,
    output logic [3:0]            wbm_sel_o,
    output logic                  wbm_we_o,
    output logic                  wbm_cyc_o,
    output logic                  wbm_stb_o,
    input  logic [31:0]           wbm_dat_i,
    input  logic                  wbm_ack_i
);

    localparam int unsigned PW = $clog2(POLL_MAX + 1);

    seq_state_e state_q, state_d;
    logic [2:0]    idx_q, idx_d;
    logic [PW-1:0] poll_q, poll_d;
    logic [191:0]  key_q;
    logic          key_dirty_q, key_valid_q;
    logic [BLK_WORDS-1:0][31:0] data_q, res_q;
    logic          dec_q;
    logic          err_q;

    logic                  req, acc_we, acc_done;
    logic [ADDR_WIDTH-1:0] acc_adr;
    logic [31:0]           acc_wdat, acc_rdat;
    logic                  accept, clr_dirty, timeout;

    logic [KEY_WORDS-1:0][31:0] key_words;
    assign key_words = key_q;

    function automatic logic [ADDR_WIDTH-1:0] word_adr(input int unsigned base,
                                                       input logic [2:0] idx);
        return ADDR_WIDTH'(base + {27'd0, idx, 2'b00});
    endfunction

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        poll_d    = poll_q;
        req       = 1'b0;
        acc_we    = 1'b1;
        acc_adr   = '0;
        acc_wdat  = '0;
        accept    = 1'b0;
        clr_dirty = 1'b0;
        timeout   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (key_dirty_q) begin
                    state_d   = StKeyWr;
                    idx_d     = '0;
                    clr_dirty = 1'b1;
                end else if (in_valid_i && in_ready_o) begin
                    state_d = StDataWr;
                    idx_d   = '0;
                    accept  = 1'b1;
                end
            end
            StKeyWr: begin
                req      = 1'b1;
                acc_adr  = word_adr(KEY_BASE, idx_q);
                acc_wdat = key_words[3'(KEY_WORDS - 1) - idx_q];
                if (acc_done) begin
                    idx_d = idx_q + 3'd1;
                    if (idx_q == 3'(KEY_WORDS - 1)) state_d = StIdle;
                end
            end
            StDataWr: begin
                req      = 1'b1;
                acc_adr  = word_adr(PT_BASE, idx_q);
                acc_wdat = data_q[~idx_q[0]];
                if (acc_done) begin
                    idx_d = idx_q + 3'd1;
                    if (idx_q == 3'(BLK_WORDS - 1)) state_d = StModeWr;
                end
            end
            StModeWr: begin
                req      = 1'b1;
                acc_adr  = ADDR_WIDTH'(MODE_ADDR);
                acc_wdat = {31'd0, dec_q};
                if (acc_done) state_d = StStartSet;
            end
            StStartSet: begin
                req      = 1'b1;
                acc_adr  = ADDR_WIDTH'(START_ADDR);
                acc_wdat = 32'd1;
                if (acc_done) state_d = StStartClr;
            end
            StStartClr: begin
                req     = 1'b1;
                acc_adr = ADDR_WIDTH'(START_ADDR);
                if (acc_done) begin
                    state_d = StPoll;
                    poll_d  = '0;
                end
            end
            StPoll: begin
                req     = 1'b1;
                acc_we  = 1'b0;
                acc_adr = ADDR_WIDTH'(DONE_ADDR);
                if (acc_done) begin
                    if (acc_rdat[0]) begin
                        state_d = StRd;
                        idx_d   = '0;
                    end else if (poll_q == PW'(POLL_MAX - 1)) begin
                        state_d = StIdle;
                        timeout = 1'b1;
                    end else begin
                        poll_d = poll_q + 1'b1;
                    end
                end
            end
            StRd: begin
                req     = 1'b1;
                acc_we  = 1'b0;
                acc_adr = word_adr(CT_BASE, idx_q);
                if (acc_done) begin
                    idx_d = idx_q + 3'd1;
                    if (idx_q == 3'(BLK_WORDS - 1)) state_d = StOut;
                end
            end
            StOut: begin
                if (out_ready_i) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            poll_q      <= '0;
            key_q       <= '0;
            key_dirty_q <= 1'b0;
            key_valid_q <= 1'b0;
            data_q      <= '0;
            res_q       <= '0;
            dec_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            poll_q  <= poll_d;
            err_q   <= timeout;
            // A fresh load wins over the clear so a key arriving on KEY_WR entry is not lost.
            if (key_load_i) begin
                key_q       <= key_i;
                key_dirty_q <= 1'b1;
                key_valid_q <= 1'b1;
            end else if (clr_dirty) begin
                key_dirty_q <= 1'b0;
            end
            if (accept) begin
                data_q <= in_data_i;
                dec_q  <= in_decrypt_i;
            end
            if (state_q == StRd && acc_done) res_q[~idx_q[0]] <= acc_rdat;
        end
    end

    assign in_ready_o  = (state_q == StIdle) & key_valid_q & ~key_dirty_q;
    assign out_valid_o = (state_q == StOut);
    assign out_data_o  = res_q;
    assign busy_o      = (state_q != StIdle);
    assign err_o       = err_q;

    des3_wb_access #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_access (
        .clk       (wb_clk_i),
        .rst       (wb_rst_i),
        .req       (req),
        .we        (acc_we),
        .adr       (acc_adr),
        .wdat      (acc_wdat),
        .done      (acc_done),
        .rdat      (acc_rdat),
        .wbm_adr_o (wbm_adr_o),
        .wbm_dat_o (wbm_dat_o),
        .wbm_sel_o (wbm_sel_o),
        .wbm_we_o  (wbm_we_o),
        .wbm_cyc_o (wbm_cyc_o),
        .wbm_stb_o (wbm_stb_o),
        .wbm_dat_i (wbm_dat_i),
        .wbm_ack_i (wbm_ack_i)
    );

endmodule

// File: tb/tb_des3_wb_sequencer.sv
// Bench for des3_wb_sequencer: a stand-in wishbone core with an invertible toy cipher,
// a scoreboard of expected results and a bus protocol monitor.
module tb_des3_wb_sequencer;

    localparam int unsigned PM = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [191:0] key;
    logic         key_load;
    logic         in_valid, in_ready, in_dec;
    logic [63:0]  in_data;
    logic         out_valid, out_ready;
    logic [63:0]  out_data;
    logic         err, busy;
    logic [31:0]  adr, wdat, rdat;
    logic [3:0]   sel;
    logic         we, cyc, stb, ack;

    always #5 clk = ~clk;

    des3_wb_sequencer #(
        .POLL_MAX (PM)
    ) dut (
        .wb_clk_i     (clk),
        .wb_rst_i     (rst),
        .key_i        (key),
        .key_load_i   (key_load),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready),
        .in_data_i    (in_data),
        .in_decrypt_i (in_dec),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .out_data_o   (out_data),
        .err_o        (err),
        .busy_o       (busy),
        .wbm_adr_o    (adr),
        .wbm_dat_o    (wdat),
        .wbm_sel_o    (sel),
        .wbm_we_o     (we),
        .wbm_cyc_o    (cyc),
        .wbm_stb_o    (stb),
        .wbm_dat_i    (rdat),
        .wbm_ack_i    (ack)
    );

    int n_vec = 0;
    int n_err = 0;
    logic [63:0] exp_q[$];
    logic [191:0] cur_key = '0;
    bit hold_low = 0, rand_stall = 0, never_done = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: bound expired at %0t", name, $time);
    endtask

    // Toy invertible cipher standing in for DES3: result depends on every key word and the mode.
    function automatic logic [63:0] toy(input logic [191:0] k, input logic [63:0] d,
                                        input logic dec);
        if (!dec) return ((d ^ k[191:128]) + k[127:64]) ^ k[63:0];
        return ((d ^ k[63:0]) - k[127:64]) ^ k[191:128];
    endfunction

    // Wishbone slave: acks one cycle after stb.
    logic [31:0] s_key[6];
    logic [31:0] s_pt[2];
    logic        s_mode;
    logic [63:0] s_res;
    int s_pend = 0, key_wr_cnt = 0, done_rd_cnt = 0, acc_cnt = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ack  <= 1'b0;
            rdat <= '0;
        end else if (cyc && stb && !ack) begin
            ack     <= 1'b1;
            acc_cnt <= acc_cnt + 1;
            if (we) begin
                if (adr < 32'h18) begin
                    s_key[adr[4:2]] <= wdat;
                    key_wr_cnt      <= key_wr_cnt + 1;
                end else if (adr == 32'h18 || adr == 32'h1C) begin
                    s_pt[adr[2]] <= wdat;
                end else if (adr == 32'h20) begin
                    s_mode <= wdat[0];
                end else if (adr == 32'h24 && wdat[0]) begin
                    s_res  <= toy({s_key[0], s_key[1], s_key[2], s_key[3], s_key[4], s_key[5]},
                                  {s_pt[0], s_pt[1]}, s_mode);
                    s_pend <= int'($urandom_range(0, 2));
                end
            end else begin
                if (adr == 32'h28) begin
                    done_rd_cnt <= done_rd_cnt + 1;
                    if (never_done) rdat <= 32'd0;
                    else if (s_pend == 0) rdat <= 32'd1;
                    else begin
                        s_pend <= s_pend - 1;
                        rdat   <= 32'd0;
                    end
                end else if (adr == 32'h2C) rdat <= s_res[63:32];
                else if (adr == 32'h30) rdat <= s_res[31:0];
                else rdat <= 32'hDEADBEEF;
            end
        end else begin
            ack <= 1'b0;
        end
    end

    // Bus protocol monitor.
    logic        pc = 0, pa = 0, pwe = 0;
    logic [31:0] padr = '0, pdat = '0;
    always @(negedge clk) begin
        if (rst) begin
            pc <= 1'b0;
            pa <= 1'b0;
        end else begin
            if (cyc) begin
                check("sel_f", sel, 4'hF);
                check("stb_eq_cyc", stb, 1'b1);
            end
            if (pc && pa) check("idle_gap", cyc, 1'b0);
            if (pc && !pa) check("held_access", {cyc, we, adr, wdat}, {1'b1, pwe, padr, pdat});
            pc   <= cyc;
            pa   <= ack;
            pwe  <= we;
            padr <= adr;
            pdat <= wdat;
        end
    end

    // Scoreboard monitor and output stability.
    int n_out = 0, err_cnt = 0;
    logic        held = 0;
    logic [63:0] held_data = '0;
    always @(negedge clk) begin
        if (!rst) begin
            if (err) err_cnt <= err_cnt + 1;
            if (out_valid) check("no_accept_in_out", in_ready, 1'b0);
            if (out_valid && out_ready) begin
                n_out <= n_out + 1;
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_out: got %h, expected no output", out_data);
                end else begin
                    check("result", out_data, exp_q.pop_front());
                end
            end
            if (out_valid && !out_ready) begin
                if (held) check("out_stable", out_data, held_data);
                held      <= 1'b1;
                held_data <= out_data;
            end else begin
                held <= 1'b0;
            end
        end else begin
            held <= 1'b0;
        end
    end

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = hold_low ? 1'b0 : (rand_stall ? 1'($urandom_range(0, 1)) : 1'b1);
        end
    end

    task automatic load_key(input logic [191:0] k);
        @(posedge clk);
        #1;
        key      = k;
        key_load = 1'b1;
        cur_key  = k;
        @(posedge clk);
        #1;
        key_load = 1'b0;
    endtask

    task automatic send_block(input logic [63:0] d, input logic dec, input logic [63:0] exp,
                              input bit push);
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_data  = d;
        in_dec   = dec;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                if (push) exp_q.push_back(exp);
                #1;
                in_valid = 1'b0;
                return;
            end
        end
        in_valid = 1'b0;
        fail("send_block");
    endtask

    task automatic drain();
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy) return;
        end
        fail("drain");
    endtask

    task automatic wait_bus(input logic [31:0] a, input logic w, input string name);
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (cyc && we == w && adr == a) return;
        end
        fail(name);
    endtask

    logic [63:0] pt, ct, d;
    logic [191:0] k;
    int kw, dr, e0, o0, a0;

    initial begin
        rst = 1'b1;
        key = '0;
        key_load = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        in_dec = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_handshake", {in_ready, out_valid, busy, err}, 4'b0000);
        check("rst_bus", {cyc, stb, we, sel}, 7'd0);
        check("rst_adr_dat", {adr, wdat}, 64'd0);
        check("rst_out_data", out_data, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // No key loaded: input must be refused and the bus must stay quiet.
        a0 = acc_cnt;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_data  = 64'h1122334455667788;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("nokey_ready", in_ready, 1'b0);
        end
        in_valid = 1'b0;
        check("nokey_bus", 64'(acc_cnt - a0), 64'd0);

        // Directed encrypt then decrypt with a fixed key.
        k  = {3{64'h133457799BBCDFF1}};
        pt = 64'h0123456789ABCDEF;
        kw = key_wr_cnt;
        load_key(k);
        ct = toy(k, pt, 1'b0);
        send_block(pt, 1'b0, ct, 1);
        drain();
        check("key_writes_first", 64'(key_wr_cnt - kw), 64'd6);
        check("key_regs_hi", {s_key[0], s_key[1], s_key[2]}, k[191:96]);
        check("key_regs_lo", {s_key[3], s_key[4], s_key[5]}, k[95:0]);
        kw = key_wr_cnt;
        send_block(ct, 1'b1, pt, 1);
        drain();
        check("key_writes_reuse", 64'(key_wr_cnt - kw), 64'd0);

        // Key change while a block is polling: old key for this block, reload before the next.
        d = {$urandom, $urandom};
        send_block(d, 1'b0, toy(cur_key, d, 1'b0), 1);
        wait_bus(32'h28, 1'b0, "wait_poll");
        kw = key_wr_cnt;
        load_key({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
        d = {$urandom, $urandom};
        send_block(d, 1'b0, toy(cur_key, d, 1'b0), 1);
        drain();
        check("key_writes_reload", 64'(key_wr_cnt - kw), 64'd6);

        // Done never set: bounded polling, error pulse, block discarded.
        never_done = 1;
        dr = done_rd_cnt;
        e0 = err_cnt;
        o0 = n_out;
        send_block({$urandom, $urandom}, 1'b0, 64'd0, 0);
        begin : wait_err
            for (int i = 0; i < 400; i++) begin
                @(negedge clk);
                if (err) disable wait_err;
            end
            fail("wait_err");
        end
        repeat (3) @(negedge clk);
        never_done = 0;
        check("timeout_polls", 64'(done_rd_cnt - dr), 64'(PM));
        check("timeout_err_pulses", 64'(err_cnt - e0), 64'd1);
        check("timeout_no_out", 64'(n_out - o0), 64'd0);
        check("timeout_ready", in_ready, 1'b1);

        // Consumer stalls for 10 cycles with a result pending.
        hold_low = 1;
        d = {$urandom, $urandom};
        send_block(d, 1'b1, toy(cur_key, d, 1'b1), 1);
        begin : wait_out
            for (int i = 0; i < 400; i++) begin
                @(negedge clk);
                if (out_valid) disable wait_out;
            end
            fail("wait_out");
        end
        repeat (10) @(negedge clk);
        check("stall_valid", out_valid, 1'b1);
        hold_low = 0;
        drain();

        // Randomised traffic with occasional key changes and consumer back-pressure.
        rand_stall = 1;
        for (int n = 0; n < 20; n++) begin
            if ($urandom_range(0, 3) == 0)
                load_key({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
            d = {$urandom, $urandom};
            in_dec = 1'($urandom_range(0, 1));
            send_block(d, in_dec, toy(cur_key, d, in_dec), 1);
        end
        drain();
        rand_stall = 0;

        // Reset in the middle of the data writes.
        send_block({$urandom, $urandom}, 1'b0, 64'd0, 0);
        wait_bus(32'h18, 1'b1, "wait_data_wr");
        #1;
        rst = 1'b1;
        #1;
        check("midrst_bus", {cyc, stb, we, sel}, 7'd0);
        check("midrst_outs", {in_ready, out_valid, busy, err}, 4'b0000);
        check("midrst_out_data", out_data, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("post_rst_keyvalid", in_ready, 1'b0);
        load_key(k);
        send_block(pt, 1'b0, toy(k, pt, 1'b0), 1);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/des3_wb_sequencer.md
# des3_wb_sequencer

Wishbone master controller that drives the DES3 core's register interface on behalf of a simple streaming client. It accepts 64-bit blocks and a 192-bit key over valid/ready handshakes, loads the key only when it has changed, and sequences the core through data write, mode select, start pulse, done polling and result readback. It returns results on an output stream. It sits between a local requester (DMA or test engine) and the DES3 wishbone slave, in place of the AXI4-Lite bridge path.

## Interface
Parameters:
- ADDR_WIDTH, 32, wishbone address width
- KEY_BASE, 'h00, byte address of key word 0; words 0..5 at KEY_BASE+4*k
- PT_BASE, 'h18, byte address of input word 0; words 0..1
- MODE_ADDR, 'h20, bit0 = 1 for decrypt
- START_ADDR, 'h24, bit0 = start
- DONE_ADDR, 'h28, bit0 = done
- CT_BASE, 'h2C, byte address of result word 0; words 0..1
- POLL_MAX, 64, done-polls before timeout (≥1)

Ports:
- wb_clk_i, in, 1, single clock
- wb_rst_i, in, 1, reset; asynchronous, active-high
- key_i, in, 192, K1 = [191:128], K2, K3 = [63:0]
- key_load_i, in, 1, single-cycle pulse; capture key_i
- in_valid_i / in_ready_o, in/out, 1, input block handshake
- in_data_i, in, 64
- in_decrypt_i, in, 1, captured with the block
- out_valid_o / out_ready_i, out/in, 1, result handshake
- out_data_o, out, 64
- err_o, out, 1, one-cycle pulse on poll timeout
- busy_o, out, 1, FSM not in IDLE
- wbm_adr_o, out, ADDR_WIDTH; wbm_dat_o, out, 32; wbm_sel_o, out, 4; wbm_we_o, wbm_cyc_o, wbm_stb_o, out, 1
- wbm_dat_i, in, 32; wbm_ack_i, in, 1

## Operation
- Word order everywhere: word 0 = most significant 32 bits. Key word k = key_i[191-32k -: 32]. wbm_sel_o is always 4'hF.
- key_load_i captures key_i into key_q and sets key_dirty, in any state. A load during a block is applied before the next block; the in-flight block completes with the old key.
- key_valid is set by the first key_load_i and cleared only by reset. in_ready_o = (state==IDLE) & key_valid & ~key_dirty.
- FSM states: IDLE, KEY_WR (6 writes), DATA_WR (2 writes), MODE_WR, START_SET (write 1), START_CLR (write 0), POLL (read DONE_ADDR), RD (2 reads), OUT, and back to IDLE.
- IDLE: if key_dirty, go to KEY_WR and clear key_dirty on entry. Otherwise, on in_valid_i & in_ready_o, capture data and mode and go to DATA_WR.
- KEY_WR returns to IDLE.
- POLL: if bit0 = 1, go to RD. If the poll count reaches POLL_MAX, pulse err_o, discard the block and go to IDLE. Otherwise re-poll.
- OUT: out_valid_o is held with stable out_data_o until out_ready_i, then go to IDLE.
- Reset mid-operation: all state clears immediately, including key_valid. Any open bus cycle is dropped with cyc/stb low.

## Timing
- Reset values: all outputs 0, including in_ready_o, out_valid_o and busy_o.
- Wishbone classic single access: cyc and stb assert together with adr, dat and we stable. They are held until the cycle wbm_ack_i is sampled high. They deassert the following cycle. The next access starts no earlier than one cycle after that (one idle cycle minimum). Read data is captured on the ack cycle.
- With a core acking one cycle after stb, each access takes 3 cycles.
- Per block: 7 + P accesses, where P = number of polls (≥1), plus 1 IDLE cycle and the OUT handshake cycle(s). A key reload adds 6 accesses.
- Back-to-back blocks: in_ready_o reasserts the cycle after the out handshake completes.
- err_o is high exactly one cycle, coincident with the transition to IDLE.

## Structure
- Package des3_seq_pkg holds:
  - the FSM state enum;
  - default register offsets;
  - the localparams KEY_WORDS=6 and BLK_WORDS=2.
- One sub-module, des3_wb_access, performs one classic wishbone access. Its handshake is req/we/adr/wdat in, and done/rdat out with a one-cycle done pulse. The FSM handles sequencing and word indexing only.

## Test plan
- Reset then in_valid_i with no key loaded: in_ready_o stays 0 and there is no bus activity.
- Load K1=K2=K3=0x133457799BBCDFF1, then encrypt 0x0123456789ABCDEF: 6 key writes then block accesses; out_data_o=0x85E813540F0AB405.
- Decrypt 0x85E813540F0AB405 with the same key: out_data_o=0x0123456789ABCDEF, and no key writes are reissued.
- key_load_i during POLL: the current result uses the old key. The next block is preceded by exactly 6 key writes.
- Slave that never sets done, with POLL_MAX=4: exactly 4 reads of DONE_ADDR, one err_o pulse, no out_valid_o, and in_ready_o returns to 1.
- Hold out_ready_i low for 10 cycles, and separately assert reset mid-DATA_WR:
  - out_data_o stays stable and no new block is accepted while out_ready_i is low;
  - on reset, cyc/stb drop immediately and all outputs return to 0.
